// File: rtl/regs_file_mc_pkg.sv
// rtl/regs_file_mc_pkg.sv - shared multi-cycle datapath definitions
// Package mc_defs_pkg: register file geometry, well-known register
// numbers and RegDst selector encodings.
package mc_defs_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

   localparam logic [15:0] WR_CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      RD_RT = 2'b00,
      RD_RD = 2'b01,
      RD_RA = 2'b10
   } regdst_e;
endpackage

// File: rtl/regs_file_mc_if.sv
// rtl/regs_file_mc_if.sv - register file access bus
// Interface regs_file_mc_if groups the write port, the A/B/debug read
// ports and the write counter.
//   we/wa/wd        write enable, address, data
//   ra1/ra2/dbg_ra  read addresses
//   rd1/rd2/dbg_rd  read data
//   wr_cnt          saturating count of committed non-$0 writes
// Modports: slave (register file side), master (datapath side).
interface regs_file_mc_if #(
   parameter int DATA_W = mc_defs_pkg::REG_DATA_W,
   parameter int ADDR_W = mc_defs_pkg::REG_ADDR_W
);
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [ADDR_W-1:0] dbg_ra;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] dbg_rd;
   logic [15:0]       wr_cnt;

   modport slave (
      input  we, wa, wd, ra1, ra2, dbg_ra,
      output rd1, rd2, dbg_rd, wr_cnt
   );

   modport master (
      output we, wa, wd, ra1, ra2, dbg_ra,
      input  rd1, rd2, dbg_rd, wr_cnt
   );
endinterface

// File: rtl/regs_file_mc_rd_port.sv
// rtl/regs_file_mc_rd_port.sv - one combinational register read port
// Module regs_rd_port. Optional feature macro: REGS_WRITE_BYPASS_EN.
// Ports:
//   ra_i   read address
//   q_i    stored register value at ra_i
//   we_i   write enable        (REGS_WRITE_BYPASS_EN only)
//   wa_i   write address       (REGS_WRITE_BYPASS_EN only)
//   wd_i   write data          (REGS_WRITE_BYPASS_EN only)
//   rd_o   read data; 0 for address 0
module regs_rd_port #(
   parameter int DATA_W = mc_defs_pkg::REG_DATA_W,
   parameter int ADDR_W = mc_defs_pkg::REG_ADDR_W
) (
   input  logic [ADDR_W-1:0] ra_i,
   input  logic [DATA_W-1:0] q_i,
`ifdef REGS_WRITE_BYPASS_EN
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wa_i,
   input  logic [DATA_W-1:0] wd_i,
`endif
   output logic [DATA_W-1:0] rd_o
);
   always_comb begin
      rd_o = q_i;
`ifdef REGS_WRITE_BYPASS_EN
      // Forward the in-flight write so the reader sees it this cycle.
      if (we_i && (wa_i == ra_i)) begin
         rd_o = wd_i;
      end
`endif
      // $0 check last: it overrides both storage and bypass.
      if (ra_i == '0) begin
         rd_o = '0;
      end
   end
endmodule

// File: rtl/regs_file_mc.sv
// rtl/regs_file_mc.sv - 32 x 32 MIPS register file, multi-cycle datapath
// Module regs_file_mc. Optional feature macro: REGS_WRITE_BYPASS_EN
// (same-cycle forwarding of wd to matching read ports).
// Ports:
//   clk   system clock, all state on posedge
//   rst   synchronous active-high reset; clears registers and wr_cnt
//   bus   regs_file_mc_if.slave: write port, three read ports, wr_cnt
module regs_file_mc
   import mc_defs_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic           clk,
   input  logic           rst,
   regs_file_mc_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [15:0]       wr_cnt_q;
   logic [15:0]       wr_cnt_d;
   logic              wr_commit;

   // Writes to $0 are dropped entirely, including from the count.
   assign wr_commit = bus.we && (bus.wa != '0);

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (wr_commit && (wr_cnt_q != WR_CNT_MAX)) begin
         wr_cnt_d = wr_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_cnt_q <= '0;
      end else begin
         if (wr_commit) begin
            mem_q[bus.wa] <= bus.wd;
         end
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign bus.wr_cnt = wr_cnt_q;

   regs_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
      .ra_i (bus.ra1),
      .q_i  (mem_q[bus.ra1]),
`ifdef REGS_WRITE_BYPASS_EN
      .we_i (bus.we),
      .wa_i (bus.wa),
      .wd_i (bus.wd),
`endif
      .rd_o (bus.rd1)
   );

   regs_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
      .ra_i (bus.ra2),
      .q_i  (mem_q[bus.ra2]),
`ifdef REGS_WRITE_BYPASS_EN
      .we_i (bus.we),
      .wa_i (bus.wa),
      .wd_i (bus.wd),
`endif
      .rd_o (bus.rd2)
   );

   regs_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_dbg (
      .ra_i (bus.dbg_ra),
      .q_i  (mem_q[bus.dbg_ra]),
`ifdef REGS_WRITE_BYPASS_EN
      .we_i (bus.we),
      .wa_i (bus.wa),
      .wd_i (bus.wd),
`endif
      .rd_o (bus.dbg_rd)
   );
endmodule

// File: tb/tb_regs_file_mc.sv
// tb/tb_regs_file_mc.sv - self-checking bench for regs_file_mc
module tb_regs_file_mc;
   import mc_defs_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regs_file_mc_if bus ();

   regs_file_mc dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   // Reference: plain array of register contents and an integer count.
   logic [31:0] model_mem [32];
   int          model_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
         model_cnt = 0;
      end else if (bus.we && bus.wa != 5'd0) begin
         model_mem[bus.wa] = bus.wd;
         if (model_cnt < 65535) model_cnt = model_cnt + 1;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef REGS_WRITE_BYPASS_EN
      if (bus.we && bus.wa == a) return bus.wd;
`endif
      return model_mem[a];
   endfunction

   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_rd1", bus.rd1, exp_rd(bus.ra1));
         chk("cyc_rd2", bus.rd2, exp_rd(bus.ra2));
         chk("cyc_dbg_rd", bus.dbg_rd, exp_rd(bus.dbg_ra));
         chk("cyc_wr_cnt", {16'h0, bus.wr_cnt}, model_cnt[31:0]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input logic w, input logic [4:0] a, input logic [31:0] d);
      bus.we = w;
      bus.wa = a;
      bus.wd = d;
   endtask

   logic [31:0] last_wd;
   logic [31:0] bypass_exp;

   initial begin
      set_wr(1'b0, 5'd0, 32'h0);
      bus.ra1 = 5'd0;
      bus.ra2 = 5'd0;
      bus.dbg_ra = 5'd0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_en = 1'b1;
      @(negedge clk);
      chk("reset_wr_cnt", {16'h0, bus.wr_cnt}, 32'h0);
      step();

      // Reset clears a written register.
      set_wr(1'b1, 5'd5, 32'hDEADBEEF);
      step();
      set_wr(1'b0, 5'd0, 32'h0);
      bus.ra1 = 5'd5;
      @(negedge clk);
      chk("r5_written", bus.rd1, 32'hDEADBEEF);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("r5_after_rst", bus.rd1, 32'h0);
      chk("cnt_after_rst", {16'h0, bus.wr_cnt}, 32'h0);
      step();

      // $0 guard.
      set_wr(1'b1, 5'd0, 32'h1234);
      step();
      set_wr(1'b0, 5'd0, 32'h0);
      bus.ra1 = 5'd0;
      @(negedge clk);
      chk("r0_guard", bus.rd1, 32'h0);
      chk("r0_no_count", {16'h0, bus.wr_cnt}, 32'h0);
      step();

      // $31 via RegDst=RA.
      set_wr(1'b1, REG_RA, 32'h0040_0008);
      step();
      set_wr(1'b0, 5'd0, 32'h0);
      bus.ra2 = 5'd31;
      @(negedge clk);
      chk("r31_rd2", bus.rd2, 32'h0040_0008);
      chk("r31_cnt", {16'h0, bus.wr_cnt}, 32'h1);
      chk("model_r31", model_mem[31], 32'h0040_0008);
      step();

      // Same-cycle read of the address being written.
      set_wr(1'b1, 5'd7, 32'h1);
      step();
      set_wr(1'b1, 5'd7, 32'h2);
      bus.ra1 = 5'd7;
`ifdef REGS_WRITE_BYPASS_EN
      bypass_exp = 32'h2;
`else
      bypass_exp = 32'h1;
`endif
      @(negedge clk);
      chk("r7_same_cycle", bus.rd1, bypass_exp);
      step();
      set_wr(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("r7_next_cycle", bus.rd1, 32'h2);
      step();

      // rst and we together: write dropped.
      rst = 1'b1;
      set_wr(1'b1, 5'd3, 32'hFF);
      step();
      rst = 1'b0;
      set_wr(1'b0, 5'd0, 32'h0);
      bus.ra1 = 5'd3;
      @(negedge clk);
      chk("r3_rst_we", bus.rd1, 32'h0);
      chk("cnt_rst_we", {16'h0, bus.wr_cnt}, 32'h0);
      step();

      // Randomised traffic with biased address collisions and rare resets.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         set_wr(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
         bus.ra1    = ($urandom_range(0, 2) == 0) ? bus.wa : 5'($urandom_range(0, 31));
         bus.ra2    = ($urandom_range(0, 3) == 0) ? bus.ra1 : 5'($urandom_range(0, 31));
         bus.dbg_ra = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
         step();
      end
      rst = 1'b0;

      // Saturation: 65536 writes to r1 from a clean state.
      rst = 1'b1;
      set_wr(1'b0, 5'd0, 32'h0);
      step();
      rst = 1'b0;
      bus.ra1 = 5'd1;
      bus.ra2 = 5'd1;
      bus.dbg_ra = 5'd2;
      last_wd = 32'h0;
      for (int i = 0; i < 65536; i++) begin
         last_wd = $urandom;
         set_wr(1'b1, 5'd1, last_wd);
         step();
      end
      set_wr(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("sat_wr_cnt", {16'h0, bus.wr_cnt}, 32'h0000_FFFF);
      chk("sat_rd1", bus.rd1, last_wd);
      chk("sat_rd2", bus.rd2, last_wd);
      step();
      set_wr(1'b1, 5'd9, 32'hA5A5_5A5A);
      step();
      set_wr(1'b0, 5'd0, 32'h0);
      bus.ra1 = 5'd9;
      @(negedge clk);
      chk("sat_hold", {16'h0, bus.wr_cnt}, 32'h0000_FFFF);
      chk("sat_r9", bus.rd1, 32'hA5A5_5A5A);
      step();

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
